// File: rtl/pyramid_color_controller.sv
// Central Q*bert position sequencer and cube top-colour bitmap for the pyramid.
// Accepts a jump, waits for the move animation, then lands and colours or falls off.
module pyramid_color_controller #(
    parameter int ROWS   = 7,
    parameter int N_cube = ROWS * (ROWS + 1) / 2,
    parameter int RW     = $clog2(ROWS),
    parameter int IW     = $clog2(N_cube)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        qbert_jump,
    input  logic              done_move,
    input  logic              restart,
    output logic [N_cube-1:0] top_color,
    output logic [RW-1:0]     qbert_row,
    output logic [RW-1:0]     qbert_col,
    output logic [IW-1:0]     cube_index,
    output logic              jump_ack,
    output logic              busy,
    output logic              fell,
    output logic              level_done
);

    localparam int SW = RW + 1;
    localparam logic signed [SW-1:0] ONE     = SW'(1);
    localparam logic signed [SW-1:0] MAX_ROW = SW'(ROWS - 1);

    typedef enum logic [2:0] {
        IDLE,
        MOVING,
        LAND,
        FALL,
        COMPLETE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [SW-1:0] cur_row;
    logic signed [SW-1:0] cur_col;
    logic signed [SW-1:0] nxt_row;
    logic signed [SW-1:0] nxt_col;
    logic                 jump_legal;
    logic                 nxt_off;

    logic [RW-1:0]        tgt_row;
    logic [RW-1:0]        tgt_col;
    logic                 tgt_off;

    logic [N_cube-1:0]    land_mask;
    logic [IW-1:0]        base [2**RW];

    // Row base offsets r*(r+1)/2 are elaboration-time constants.
    for (genvar g = 0; g < 2**RW; g++) begin : g_base
        assign base[g] = IW'(g * (g + 1) / 2);
    end

    always_comb begin
        cur_row    = $signed({1'b0, qbert_row});
        cur_col    = $signed({1'b0, qbert_col});
        nxt_row    = cur_row;
        nxt_col    = cur_col;
        jump_legal = 1'b1;
        case (qbert_jump)
            3'b001: nxt_row = cur_row - ONE;
            3'b010: begin
                nxt_row = cur_row - ONE;
                nxt_col = cur_col - ONE;
            end
            3'b011: nxt_row = cur_row + ONE;
            3'b100: begin
                nxt_row = cur_row + ONE;
                nxt_col = cur_col + ONE;
            end
            default: jump_legal = 1'b0;
        endcase
        // Any wrap past the top of the signed range lands negative and reads as off.
        nxt_off = nxt_row[SW-1] || (nxt_row > MAX_ROW) ||
                  nxt_col[SW-1] || (nxt_col > nxt_row);
    end

    assign land_mask = N_cube'(1) << cube_index;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (jump_legal) state_nxt = MOVING;
            MOVING:   if (done_move) state_nxt = tgt_off ? FALL : LAND;
            LAND:     state_nxt = (&(top_color | land_mask)) ? COMPLETE : IDLE;
            FALL:     if (restart) state_nxt = IDLE;
            COMPLETE: if (restart) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_color  <= N_cube'(1);
            qbert_row  <= '0;
            qbert_col  <= '0;
            cube_index <= '0;
            jump_ack   <= 1'b0;
            tgt_row    <= '0;
            tgt_col    <= '0;
            tgt_off    <= 1'b0;
        end else begin
            jump_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (jump_legal) begin
                        jump_ack <= 1'b1;
                        tgt_row  <= nxt_row[RW-1:0];
                        tgt_col  <= nxt_col[RW-1:0];
                        tgt_off  <= nxt_off;
                    end
                end
                MOVING: begin
                    if (done_move && !tgt_off) begin
                        qbert_row  <= tgt_row;
                        qbert_col  <= tgt_col;
                        cube_index <= base[tgt_row] + IW'(tgt_col);
                    end
                end
                LAND: top_color <= top_color | land_mask;
                FALL: begin
                    if (restart) begin
                        qbert_row  <= '0;
                        qbert_col  <= '0;
                        cube_index <= '0;
                    end
                end
                COMPLETE: begin
                    if (restart) begin
                        top_color  <= N_cube'(1);
                        qbert_row  <= '0;
                        qbert_col  <= '0;
                        cube_index <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state == MOVING) || (state == LAND);
    assign fell       = (state == FALL);
    assign level_done = (state == COMPLETE);

endmodule

// File: tb/tb_pyramid_color_controller.sv
// Bench for pyramid_color_controller: vector table, randomized jumps against a
// position/bitmap model, a full-pyramid tour, mid-move reset and a 2-row instance.
module tb_pyramid_color_controller;

    localparam int ROWS = 7;
    localparam logic [27:0] ALL = '1;

    logic        clk;
    logic        reset;
    logic [2:0]  qbert_jump;
    logic        done_move;
    logic        restart;
    logic [27:0] top_color;
    logic [2:0]  qbert_row;
    logic [2:0]  qbert_col;
    logic [4:0]  cube_index;
    logic        jump_ack;
    logic        busy;
    logic        fell;
    logic        level_done;

    logic [2:0]  j2;
    logic        dm2;
    logic        rs2;
    logic [2:0]  top2;
    logic [0:0]  row2;
    logic [0:0]  col2;
    logic [1:0]  idx2;
    logic        ack2;
    logic        busy2;
    logic        fell2;
    logic        ld2;

    pyramid_color_controller #(.ROWS(7)) dut (
        .clk(clk), .reset(reset), .qbert_jump(qbert_jump), .done_move(done_move),
        .restart(restart), .top_color(top_color), .qbert_row(qbert_row),
        .qbert_col(qbert_col), .cube_index(cube_index), .jump_ack(jump_ack),
        .busy(busy), .fell(fell), .level_done(level_done)
    );

    pyramid_color_controller #(.ROWS(2)) dut2 (
        .clk(clk), .reset(reset), .qbert_jump(j2), .done_move(dm2),
        .restart(rs2), .top_color(top2), .qbert_row(row2),
        .qbert_col(col2), .cube_index(idx2), .jump_ack(ack2),
        .busy(busy2), .fell(fell2), .level_done(ld2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors;
    int          checks;
    int          cur_row;
    int          cur_col;
    logic [27:0] cur_top;
    bit          completed;

    typedef struct {
        logic [2:0]  code;
        int          dly;
        bit          ack;
        bit          fall;
        int          r;
        int          c;
        int          idx;
        logic [27:0] top;
    } vec_t;

    vec_t tbl[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: geometry of the pyramid with plain integer arithmetic.
    task automatic predict(input logic [2:0] code, output bit ack, output bit fall,
                           output int er, output int ec, output int ei,
                           output logic [27:0] etop);
        int dr, dc, tr, tc;
        ack = 1'b1;
        dr  = 0;
        dc  = 0;
        case (code)
            3'd1: begin dr = -1; dc = 0;  end
            3'd2: begin dr = -1; dc = -1; end
            3'd3: begin dr = 1;  dc = 0;  end
            3'd4: begin dr = 1;  dc = 1;  end
            default: ack = 1'b0;
        endcase
        tr   = cur_row + dr;
        tc   = cur_col + dc;
        fall = ack && (tr < 0 || tr > ROWS - 1 || tc < 0 || tc > tr);
        if (!ack || fall) begin
            er   = cur_row;
            ec   = cur_col;
            etop = cur_top;
        end else begin
            er   = tr;
            ec   = tc;
            etop = cur_top | (28'd1 << (tr * (tr + 1) / 2 + tc));
        end
        ei = er * (er + 1) / 2 + ec;
    endtask

    task automatic choose(output logic [2:0] code);
        logic [2:0] pref[$];
        logic [2:0] legal[$];
        for (int k = 1; k <= 4; k++) begin
            int tr, tc;
            tr = cur_row + ((k <= 2) ? -1 : 1);
            tc = cur_col + ((k == 2) ? -1 : (k == 4) ? 1 : 0);
            if (tr >= 0 && tr < ROWS && tc >= 0 && tc <= tr) begin
                legal.push_back(3'(k));
                if (!cur_top[tr * (tr + 1) / 2 + tc]) pref.push_back(3'(k));
            end
        end
        if (pref.size() > 0) code = pref[$urandom_range(0, pref.size() - 1)];
        else                 code = legal[$urandom_range(0, legal.size() - 1)];
    endtask

    task automatic run_jump(input logic [2:0] code, input int dly, input bit e_ack,
                            input bit e_fall, input int er, input int ec, input int ei,
                            input logic [27:0] e_top);
        bit lvl;
        lvl        = 1'b0;
        qbert_jump = code;
        restart    = 1'($urandom_range(0, 1));
        done_move  = 1'($urandom_range(0, 1));
        step();
        qbert_jump = 3'd0;
        restart    = 1'b0;
        done_move  = 1'b0;
        chk("jump_ack", jump_ack, e_ack);
        chk("busy_accept", busy, e_ack);
        if (!e_ack) begin
            chk("idle_row", qbert_row, cur_row);
            chk("idle_col", qbert_col, cur_col);
            chk("idle_top", top_color, cur_top);
            return;
        end
        for (int i = 0; i < dly; i++) begin
            qbert_jump = 3'($urandom_range(1, 4));
            restart    = 1'($urandom_range(0, 1));
            step();
            qbert_jump = 3'd0;
            restart    = 1'b0;
            chk("moving_ack", jump_ack, 1'b0);
            chk("moving_busy", busy, 1'b1);
            chk("moving_row", qbert_row, cur_row);
            chk("moving_col", qbert_col, cur_col);
        end
        done_move = 1'b1;
        step();
        done_move = 1'b0;
        chk("pos_row", qbert_row, er);
        chk("pos_col", qbert_col, ec);
        chk("pos_idx", cube_index, ei);
        chk("fell", fell, e_fall);
        chk("busy_done", busy, !e_fall);
        if (e_fall) begin
            qbert_jump = 3'd3;
            step();
            qbert_jump = 3'd0;
            chk("fall_hold", fell, 1'b1);
            chk("fall_noack", jump_ack, 1'b0);
            restart = 1'b1;
            step();
            restart = 1'b0;
            chk("restart_fell", fell, 1'b0);
            chk("restart_row", qbert_row, 0);
            chk("restart_col", qbert_col, 0);
            chk("restart_idx", cube_index, 0);
            chk("restart_top", top_color, e_top);
            cur_row = 0;
            cur_col = 0;
        end else begin
            chk("land_top_pending", top_color, cur_top);
            step();
            chk("land_top", top_color, e_top);
            chk("land_exit_busy", busy, 1'b0);
            if (e_top == ALL) begin
                chk("level_done", level_done, 1'b1);
                qbert_jump = 3'd3;
                step();
                qbert_jump = 3'd0;
                chk("complete_hold", level_done, 1'b1);
                chk("complete_noack", jump_ack, 1'b0);
                restart = 1'b1;
                step();
                restart = 1'b0;
                chk("next_level_done", level_done, 1'b0);
                chk("next_level_top", top_color, 28'h1);
                chk("next_level_row", qbert_row, 0);
                chk("next_level_col", qbert_col, 0);
                chk("next_level_idx", cube_index, 0);
                lvl       = 1'b1;
                completed = 1'b1;
                cur_row   = 0;
                cur_col   = 0;
            end else begin
                chk("level_done_low", level_done, 1'b0);
                cur_row = er;
                cur_col = ec;
            end
        end
        cur_top = lvl ? 28'h1 : e_top;
    endtask

    task automatic jump2(input logic [2:0] code);
        j2 = code;
        step();
        j2 = 3'd0;
        chk("d2_ack", ack2, 1'b1);
        dm2 = 1'b1;
        step();
        dm2 = 1'b0;
        step();
    endtask

    initial begin
        bit          p_ack, p_fall;
        int          p_r, p_c, p_i;
        logic [27:0] p_top;
        logic [2:0]  code;

        errors     = 0;
        checks     = 0;
        completed  = 1'b0;
        reset      = 1'b1;
        qbert_jump = 3'd0;
        done_move  = 1'b0;
        restart    = 1'b0;
        j2         = 3'd0;
        dm2        = 1'b0;
        rs2        = 1'b0;
        cur_row    = 0;
        cur_col    = 0;
        cur_top    = 28'h1;

        step();
        step();
        chk("rst_top", top_color, 28'h1);
        chk("rst_row", qbert_row, 0);
        chk("rst_col", qbert_col, 0);
        chk("rst_idx", cube_index, 0);
        chk("rst_flags", {jump_ack, busy, fell, level_done}, 4'b0000);
        reset = 1'b0;
        step();

        tbl[0]  = '{3'b011, 0, 1'b1, 1'b0, 1, 0, 1, 28'h03};
        tbl[1]  = '{3'b111, 0, 1'b0, 1'b0, 1, 0, 1, 28'h03};
        tbl[2]  = '{3'b100, 1, 1'b1, 1'b0, 2, 1, 4, 28'h13};
        tbl[3]  = '{3'b001, 2, 1'b1, 1'b0, 1, 1, 2, 28'h17};
        tbl[4]  = '{3'b100, 0, 1'b1, 1'b0, 2, 2, 5, 28'h37};
        tbl[5]  = '{3'b001, 1, 1'b1, 1'b1, 2, 2, 5, 28'h37};
        tbl[6]  = '{3'b001, 0, 1'b1, 1'b1, 0, 0, 0, 28'h37};
        tbl[7]  = '{3'b010, 3, 1'b1, 1'b1, 0, 0, 0, 28'h37};
        tbl[8]  = '{3'b000, 0, 1'b0, 1'b0, 0, 0, 0, 28'h37};
        tbl[9]  = '{3'b100, 0, 1'b1, 1'b0, 1, 1, 2, 28'h37};
        tbl[10] = '{3'b010, 1, 1'b1, 1'b0, 0, 0, 0, 28'h37};
        tbl[11] = '{3'b011, 0, 1'b1, 1'b0, 1, 0, 1, 28'h37};
        tbl[12] = '{3'b011, 2, 1'b1, 1'b0, 2, 0, 3, 28'h3F};

        for (int t = 0; t < 13; t++) begin
            run_jump(tbl[t].code, tbl[t].dly, tbl[t].ack, tbl[t].fall,
                     tbl[t].r, tbl[t].c, tbl[t].idx, tbl[t].top);
        end

        done_move = 1'b1;
        step();
        done_move = 1'b0;
        chk("idle_done_busy", busy, 1'b0);
        chk("idle_done_row", qbert_row, cur_row);
        chk("idle_done_top", top_color, cur_top);

        for (int n = 0; n < 120; n++) begin
            code = 3'($urandom_range(0, 7));
            predict(code, p_ack, p_fall, p_r, p_c, p_i, p_top);
            run_jump(code, $urandom_range(0, 3), p_ack, p_fall, p_r, p_c, p_i, p_top);
        end

        completed = 1'b0;
        for (int n = 0; n < 3000 && !completed; n++) begin
            choose(code);
            predict(code, p_ack, p_fall, p_r, p_c, p_i, p_top);
            run_jump(code, $urandom_range(0, 1), p_ack, p_fall, p_r, p_c, p_i, p_top);
        end
        chk("tour_completed", completed, 1'b1);

        predict(3'd3, p_ack, p_fall, p_r, p_c, p_i, p_top);
        run_jump(3'd3, 0, p_ack, p_fall, p_r, p_c, p_i, p_top);
        qbert_jump = 3'd4;
        step();
        qbert_jump = 3'd0;
        chk("pre_reset_ack", jump_ack, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_top", top_color, 28'h1);
        chk("async_rst_row", qbert_row, 0);
        chk("async_rst_idx", cube_index, 0);
        chk("async_rst_flags", {jump_ack, busy, fell, level_done}, 4'b0000);
        step();
        reset = 1'b0;
        cur_row = 0;
        cur_col = 0;
        cur_top = 28'h1;
        done_move = 1'b1;
        step();
        done_move = 1'b0;
        step();
        chk("post_rst_row", qbert_row, 0);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_top", top_color, 28'h1);

        jump2(3'd3);
        chk("d2_top_a", top2, 3'b011);
        chk("d2_ld_a", ld2, 1'b0);
        jump2(3'd1);
        chk("d2_row_b", row2, 1'b0);
        chk("d2_top_b", top2, 3'b011);
        jump2(3'd4);
        chk("d2_top_c", top2, 3'b111);
        chk("d2_ld_c", ld2, 1'b1);
        chk("d2_pos_c", {row2, col2, idx2}, 4'b1110);
        rs2 = 1'b1;
        step();
        rs2 = 1'b0;
        chk("d2_restart_top", top2, 3'b001);
        chk("d2_restart_ld", ld2, 1'b0);
        chk("d2_restart_row", row2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
